// File: rtl/saw2sin_seq.sv
// Sequential sawtooth-to-sine converter: Bhaskara-I approximation with a bit-serial restoring divider.
// Optional build macro SAW2SIN_ROUND_EN adds half the divisor to the numerator for round-to-nearest.
module saw2sin_seq #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_saw,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_sin,
    output logic         o_valid,
    input  logic         i_ready
);

    localparam int IW = 3*W + 3;        // full numerator width
    localparam int DW = 2*W + 3;        // divisor / remainder width
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_OUT} state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_valid;
    logic [W-1:0]    r_sin;
    logic [CW-1:0]   r_cnt;

    logic [W-1:0]    r_x;
    logic            r_inv;
    logic [DW-1:0]   r_den;
    logic [DW-1:0]   r_rem;
    logic [W:0]      r_num;
    logic [W-1:0]    r_quo;

    logic [W-1:0]    w_x_next;
    logic [IW-1:0]   w_x;
    logic [IW-1:0]   w_m;
    logic [DW-1:0]   w_den;
    logic [IW-1:0]   w_n;
    logic [DW:0]     w_trial;
    logic            w_ge;
    logic [W-1:0]    w_s;
    logic [W-1:0]    w_sin;
    logic            w_accept;

    assign w_accept = (r_state == S_IDLE) && i_valid;

    // Second and fourth quadrants mirror the phase; the 01 tail centres the mirrored grid.
    assign w_x_next = i_saw[W-2] ? {~i_saw[W-3:0], 2'b01} : {i_saw[W-3:0], 2'b00};

    assign w_x   = IW'(r_x);
    assign w_m   = w_x * ((IW'(1) << (W + 1)) - w_x);
    assign w_den = (DW'(5) << (2*W)) - w_m[DW-1:0];

`ifdef SAW2SIN_ROUND_EN
    assign w_n = (w_m << (W + 2)) + IW'(w_den >> 1);
`else
    assign w_n = w_m << (W + 2);
`endif

    // The quotient never reaches 2^(W+1), so the upper numerator bits start out as the remainder
    // and only the low W+1 bits have to be shifted through the divider.
    assign w_trial = {r_rem, r_num[W]};
    assign w_ge    = (w_trial >= (DW+1)'(r_den));

    // At the last divide step r_quo already holds q[W:1]; q[W] set means saturation.
    assign w_s   = {1'b1, (r_quo[W-1] ? {(W-1){1'b1}} : r_quo[W-2:0])};
    assign w_sin = r_inv ? (~w_s + W'(1)) : w_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_sin   <= {1'b1, {(W-1){1'b0}}};
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_state <= S_MUL;
                        r_ready <= 1'b0;
                    end
                end
                S_MUL: begin
                    r_state <= S_DIV;
                    r_cnt   <= '0;
                end
                S_DIV: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(W)) begin
                        r_state <= S_OUT;
                        r_valid <= 1'b1;
                        r_sin   <= w_sin;
                    end
                end
                S_OUT: begin
                    if (i_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; the FSM never lets an unloaded value reach o_sin.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_x   <= w_x_next;
            r_inv <= i_saw[W-1];
        end
        if (r_state == S_MUL) begin
            r_den <= w_den;
            r_rem <= DW'(w_n[IW-1:W+1]);
            r_num <= w_n[W:0];
            r_quo <= '0;
        end
        if (r_state == S_DIV) begin
            r_rem <= w_ge ? DW'(w_trial - (DW+1)'(r_den)) : w_trial[DW-1:0];
            r_num <= {r_num[W-1:0], 1'b0};
            r_quo <= {r_quo[W-2:0], w_ge};
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_sin   = r_sin;

endmodule
